// File: rtl/ltf_csi_averager.sv
// Two-symbol LTF averager: buffers LTF symbol 1 per subcarrier, adds symbol 2 on arrival,
// then scales, saturates and streams one CSI estimate per subcarrier.
module ltf_csi_averager #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int NUM_SC    = 64,
  parameter int SHIFT     = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic signed [IN_WIDTH-1:0]    i_in,
  input  logic signed [IN_WIDTH-1:0]    q_in,
  input  logic                          valid_in,
  output logic signed [OUT_WIDTH-1:0]   i_out,
  output logic signed [OUT_WIDTH-1:0]   q_out,
  output logic                          valid_out,
  output logic [$clog2(NUM_SC)-1:0]     sc_idx_out,
  output logic                          done_out,
  output logic                          sat_out,
  output logic                          busy_out
);

  localparam int IDX_W = $clog2(NUM_SC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SC - 1);
  localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, SYM1, SYM2} state_t;

  function automatic logic signed [IN_WIDTH:0] scale(input logic signed [IN_WIDTH:0] s);
    return s >>> SHIFT;
  endfunction

  function automatic logic over_range(input logic signed [IN_WIDTH:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [IN_WIDTH:0] v);
    if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic                   gen;
  logic                   wr_en, rd_en;

  logic [2*IN_WIDTH-1:0]  mem [NUM_SC];
  logic [2*IN_WIDTH-1:0]  rd_data;
  logic signed [IN_WIDTH-1:0] buf_i, buf_q;

  logic                   vld_p0, vld_p1;
  logic signed [IN_WIDTH-1:0] i_p0, q_p0;
  logic [IDX_W-1:0]       idx_p0, idx_p1;
  logic                   gen_p0, gen_p1;
  logic signed [IN_WIDTH:0] sum_i_p1, sum_q_p1;

  logic signed [IN_WIDTH:0] scaled_i, scaled_q;
  logic                   clip_i, clip_q;

  // A coincident start_in drops the sample, so it never writes or reads the buffer.
  assign wr_en    = (state == SYM1) && valid_in && !start_in;
  assign rd_en    = (state == SYM2) && valid_in && !start_in;
  assign busy_out = (state != IDLE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (start_in) begin
      state_nxt = SYM1;
      idx_nxt   = '0;
    end else begin
      case (state)
        SYM1: if (valid_in) begin
          idx_nxt = idx + 1'b1;
          if (idx == LAST_IDX) state_nxt = SYM2;
        end
        SYM2: if (valid_in) begin
          idx_nxt = idx + 1'b1;
          if (idx == LAST_IDX) state_nxt = IDLE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      idx   <= '0;
      gen   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (start_in) gen <= ~gen;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[idx] <= {i_in, q_in};
    if (rd_en) rd_data  <= mem[idx];
  end

  assign buf_i = rd_data[2*IN_WIDTH-1:IN_WIDTH];
  assign buf_q = rd_data[IN_WIDTH-1:0];

  // Stage 1: RAM read alongside the registered symbol-2 sample
  always_ff @(posedge clk_in) begin
    if (rst_in) vld_p0 <= 1'b0;
    else        vld_p0 <= rd_en;
  end

  always_ff @(posedge clk_in) begin
    if (rd_en) begin
      i_p0   <= i_in;
      q_p0   <= q_in;
      idx_p0 <= idx;
      gen_p0 <= gen;
    end
  end

  // Stage 1b: widened two-symbol sum, cannot overflow
  always_ff @(posedge clk_in) begin
    if (rst_in) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk_in) begin
    if (vld_p0) begin
      sum_i_p1 <= (IN_WIDTH+1)'(i_p0) + (IN_WIDTH+1)'(buf_i);
      sum_q_p1 <= (IN_WIDTH+1)'(q_p0) + (IN_WIDTH+1)'(buf_q);
      idx_p1   <= idx_p0;
      gen_p1   <= gen_p0;
    end
  end

  assign scaled_i = scale(sum_i_p1);
  assign scaled_q = scale(sum_q_p1);
  assign clip_i   = over_range(scaled_i);
  assign clip_q   = over_range(scaled_q);

  // Stage 2: shift, saturate, output register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out  <= 1'b0;
      done_out   <= 1'b0;
      sat_out    <= 1'b0;
      i_out      <= '0;
      q_out      <= '0;
      sc_idx_out <= '0;
    end else begin
      valid_out <= vld_p1;
      done_out  <= vld_p1 && (idx_p1 == LAST_IDX);
      if (vld_p1) begin
        i_out      <= saturate(scaled_i);
        q_out      <= saturate(scaled_q);
        sc_idx_out <= idx_p1;
      end
      // Leftover outputs of an aborted pair must not flag the new pair.
      if (start_in)
        sat_out <= 1'b0;
      else if (vld_p1 && (gen_p1 == gen) && (clip_i || clip_q))
        sat_out <= 1'b1;
    end
  end

endmodule

// File: doc/ltf_csi_averager.md
# ltf_csi_averager

Averages the two 802.11 long-training-field (LTF) symbols of a frame, per subcarrier, to produce one channel-state-information (CSI) estimate per subcarrier. It sits directly downstream of the complex multiplier, which outputs received LTF times conjugated reference at 2*16 bits. The block buffers symbol 1 in an internal RAM, adds symbol 2 on arrival, then scales, saturates and streams the averaged CSI to the CSI output FIFO/AXI packer.

## Interface
- IN_WIDTH, 32: width of each incoming product component (signed).
- OUT_WIDTH, 16: width of each output CSI component (signed).
- NUM_SC, 64: subcarriers per LTF symbol. Power of two, 4..256.
- SHIFT, 16: arithmetic right shift applied to the two-symbol sum.
- clk_in  input  1: single clock; all logic on rising edge.
- rst_in  input  1: synchronous, active-high reset.
- start_in  input  1: one-cycle pulse arming capture of a new LTF pair.
- i_in, q_in  input  IN_WIDTH each: signed product from the complex multiplier.
- valid_in  input  1: i_in/q_in carry a sample this cycle. No backpressure.
- i_out, q_out  output  OUT_WIDTH each: signed averaged CSI.
- valid_out  output  1: i_out/q_out/sc_idx_out valid this cycle.
- sc_idx_out  output  $clog2(NUM_SC): subcarrier index of the current output.
- done_out  output  1: one-cycle pulse coincident with the last valid_out of a pair.
- sat_out  output  1: sticky; some output of the current pair saturated.
- busy_out  output  1: high in SYM1 and SYM2.

## Operation
- FSM states: IDLE, SYM1, SYM2.
- IDLE: valid_in ignored. start_in moves to SYM1, clears the index counter and sat_out.
- SYM1: each valid_in writes {i_in, q_in} to buffer[idx], then idx++. After sample NUM_SC-1, idx wraps to 0 and state moves to SYM2.
- SYM2: each valid_in reads buffer[idx] and forms sum_i = i_in + buf_i and sum_q = q_in + buf_q. Sums are IN_WIDTH+1 bits, sign-extended, so no overflow. idx++.
- After sample NUM_SC-1 of SYM2, state returns to IDLE.
- Scaling: y = sum >>> SHIFT (arithmetic shift, floor rounding).
- Saturation: y is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Any clamp on i or q sets sat_out. sat_out holds until the next start_in or reset.
- start_in in SYM1 or SYM2 aborts the current pair and restarts in SYM1 with idx=0 and sat_out cleared. A start_in and valid_in in the same cycle: the sample is dropped, and capture begins with the next valid_in.
- Outputs already in the pipeline when an abort occurs still emit. done_out is not asserted for the aborted pair.
- Buffer: NUM_SC x 2*IN_WIDTH simple dual-port RAM with synchronous read, inferable as BRAM. Contents are not reset.
- sc_idx_out equals the idx of the SYM2 sample that produced the output.
- Gaps in valid_in are allowed in any state. The pipeline advances only on valid data, and output order equals input order.

## Timing
- Reset: state=IDLE, idx=0. valid_out, done_out, sat_out and busy_out are 0. i_out, q_out and sc_idx_out are 0.
- rst_in overrides everything, including a coincident start_in. Pipeline valid bits clear, so no output emits after reset.
- busy_out is high from the cycle after start_in until the cycle after the last SYM2 sample.
- Latency: SYM2 sample accepted at edge N gives valid_out high after edge N+2.
  - Stage 1: RAM read plus input register.
  - Stage 2: add, shift, saturate, output register.
- valid_out is a single-cycle pulse per sample. Throughput is 1 sample/cycle.
- done_out rises with the valid_out for sc_idx_out = NUM_SC-1.
- A new start_in is legal the cycle after the last SYM2 sample. Back-to-back pairs must not corrupt the in-flight outputs.
- SYM1 writes and SYM2 reads never target the same address in one cycle, so no read-during-write hazard exists.

## Test plan
- Basic average: start_in, then 64 samples of i=0x00030000, q=-0x00010000 in each symbol -> 64 outputs with i=6, q=-2, sc_idx 0..63, done_out on idx 63, sat_out=0.
- Per-subcarrier ramp: SYM1 i=k<<16, SYM2 i=(k+1)<<16, q=0 -> i_out=2k+1 at sc_idx=k, exact latency of 2 cycles from each SYM2 sample.
- Saturation and rounding:
  - Both symbols i=0x7FFFFFFF -> i_out=32767 with sat_out set.
  - i=-0x80000000 -> i_out=-32768.
  - Sum -1 -> output -1 (floor).
  - sat_out clears on the next start_in.
- Gapped input: random valid_in duty of 30% across both symbols -> output values and order identical to the gap-free run, with no extra valid_out.
- Abort and reset:
  - start_in mid-SYM2 (after 20 samples) -> pending outputs emit and no done_out. A fresh pair then averages correctly.
  - rst_in mid-SYM1 -> all outputs 0 and state IDLE the next cycle. valid_in is ignored until start_in.
- Back-to-back: second start_in the cycle after the last SYM2 sample -> both pairs produce 64 correct outputs and two done_out pulses.
